sram_req_arbiter: RTL and testbench

Arbitrates the instruction-fetch and data-access SRAM-like masters onto one shared SRAM-like memory port. Tracks the owner of every accepted, still-outstanding request in issue order, so each returning `data_ok`/`rdata` beat is routed back to the master that issued it. Sits between the IF/MEM pipeline stages and the single memory-side bridge.

---
 rtl/sram_arb_pkg.sv | 11 +
 rtl/sram_req_arbiter_owner_fifo.sv | 56 +++++
 rtl/sram_req_arbiter.sv | 114 +++++++++++
 tb/tb_sram_req_arbiter.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/sram_arb_pkg.sv
// Shared constants for the SRAM request arbiter: owner tags and access-size encodings.
package sram_arb_pkg;

    localparam logic OWNER_INST = 1'b0;
    localparam logic OWNER_DATA = 1'b1;

    localparam logic [1:0] SIZE_B = 2'b00;
    localparam logic [1:0] SIZE_H = 2'b01;
    localparam logic [1:0] SIZE_W = 2'b10;

endpackage

// File: rtl/sram_req_arbiter_owner_fifo.sv
// One-bit-wide synchronous FIFO recording which master owns each outstanding request.
module owner_fifo #(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic                     din,
    input  logic                     pop,
    output logic                     dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [DEPTH-1:0] r_mem;
    logic [PW-1:0]    r_wptr;
    logic [PW-1:0]    r_rptr;
    logic [CW-1:0]    r_count;
    logic             w_do_push;
    logic             w_do_pop;

    assign full      = (r_count == CW'(DEPTH));
    assign empty     = (r_count == '0);
    assign count     = r_count;
    assign dout      = r_mem[r_rptr];
    assign w_do_push = push & ~full;
    assign w_do_pop  = pop & ~empty;

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mem   <= '0;
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_do_push) begin
                r_mem[r_wptr] <= din;
                r_wptr        <= r_wptr + PW'(1);
            end
            if (w_do_pop) begin
                r_rptr <= r_rptr + PW'(1);
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/sram_req_arbiter.sv
// Fixed-priority arbiter of the fetch and data SRAM-like masters onto one memory port,
// routing each returning beat to its issuer via an in-order owner FIFO.
module sram_req_arbiter
    import sram_arb_pkg::*;
#(
    parameter int OUTSTANDING = 4
) (
    input  logic                            clk,
    input  logic                            resetn,
    input  logic                            inst_req,
    input  logic                            inst_wr,
    input  logic [1:0]                      inst_size,
    input  logic [31:0]                     inst_addr,
    input  logic [3:0]                      inst_wstrb,
    input  logic [31:0]                     inst_wdata,
    output logic                            inst_addr_ok,
    output logic                            inst_data_ok,
    output logic [31:0]                     inst_rdata,
    input  logic                            data_req,
    input  logic                            data_wr,
    input  logic [1:0]                      data_size,
    input  logic [31:0]                     data_addr,
    input  logic [3:0]                      data_wstrb,
    input  logic [31:0]                     data_wdata,
    output logic                            data_addr_ok,
    output logic                            data_data_ok,
    output logic [31:0]                     data_rdata,
    output logic                            mem_req,
    output logic                            mem_wr,
    output logic [1:0]                      mem_size,
    output logic [31:0]                     mem_addr,
    output logic [3:0]                      mem_wstrb,
    output logic [31:0]                     mem_wdata,
    input  logic                            mem_addr_ok,
    input  logic                            mem_data_ok,
    input  logic [31:0]                     mem_rdata,
    output logic [$clog2(OUTSTANDING):0]    pending_cnt,
    output logic                            proto_err
);

    logic w_full;
    logic w_empty;
    logic w_head;
    logic w_grant_data;
    logic w_grant_inst;
    logic w_acc;
    logic w_ret;
    logic w_owner;
    logic r_proto_err;

    // Grant is recomputed every cycle; a full FIFO blocks issue even if a pop lands this cycle.
    assign w_grant_data = resetn & data_req & ~w_full;
    assign w_grant_inst = resetn & inst_req & ~data_req & ~w_full;
    assign mem_req      = w_grant_data | w_grant_inst;

    always_comb begin
        mem_wr    = 1'b0;
        mem_size  = 2'b00;
        mem_addr  = 32'h0;
        mem_wstrb = 4'h0;
        mem_wdata = 32'h0;
        if (w_grant_data) begin
            mem_wr    = data_wr;
            mem_size  = data_size;
            mem_addr  = data_addr;
            mem_wstrb = data_wstrb;
            mem_wdata = data_wdata;
        end else if (w_grant_inst) begin
            mem_wr    = inst_wr;
            mem_size  = inst_size;
            mem_addr  = inst_addr;
            mem_wstrb = inst_wstrb;
            mem_wdata = inst_wdata;
        end
    end

    assign data_addr_ok = w_grant_data & mem_addr_ok;
    assign inst_addr_ok = w_grant_inst & mem_addr_ok;

    assign w_acc   = mem_req & mem_addr_ok;
    assign w_ret   = resetn & mem_data_ok & ~w_empty;
    assign w_owner = w_grant_data ? OWNER_DATA : OWNER_INST;

    assign data_data_ok = w_ret & (w_head == OWNER_DATA);
    assign inst_data_ok = w_ret & (w_head == OWNER_INST);
    assign inst_rdata   = mem_rdata;
    assign data_rdata   = mem_rdata;

    // A beat with nothing outstanding has no owner; flag it until the next reset.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_proto_err <= 1'b0;
        end else if (mem_data_ok & w_empty) begin
            r_proto_err <= 1'b1;
        end
    end

    assign proto_err = r_proto_err;

    owner_fifo #(
        .DEPTH (OUTSTANDING)
    ) u_owner_fifo (
        .clk   (clk),
        .rst_n (resetn),
        .push  (w_acc),
        .din   (w_owner),
        .pop   (w_ret),
        .dout  (w_head),
        .full  (w_full),
        .empty (w_empty),
        .count (pending_cnt)
    );

endmodule

// File: tb/tb_sram_req_arbiter.sv
// Directed and randomized bench for sram_req_arbiter against a queue-based ownership model.
module tb_sram_req_arbiter;
    import sram_arb_pkg::*;

    localparam int OUT = 4;

    logic        clk;
    logic        resetn;
    logic        inst_req, inst_wr, data_req, data_wr;
    logic [1:0]  inst_size, data_size, mem_size;
    logic [31:0] inst_addr, inst_wdata, data_addr, data_wdata;
    logic [3:0]  inst_wstrb, data_wstrb, mem_wstrb;
    logic        inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok;
    logic [31:0] inst_rdata, data_rdata;
    logic        mem_req, mem_wr, mem_addr_ok, mem_data_ok;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [$clog2(OUT):0] pending_cnt;
    logic        proto_err;

    int vectors;
    int miscompares;

    // Reference model: the ordered list of owners still awaiting a response.
    bit q[$];
    bit mProto;
    bit lastAcc, lastRet, lastErr, lastOwner;

    sram_req_arbiter #(.OUTSTANDING(OUT)) dut (
        .clk(clk), .resetn(resetn),
        .inst_req(inst_req), .inst_wr(inst_wr), .inst_size(inst_size), .inst_addr(inst_addr),
        .inst_wstrb(inst_wstrb), .inst_wdata(inst_wdata),
        .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
        .data_req(data_req), .data_wr(data_wr), .data_size(data_size), .data_addr(data_addr),
        .data_wstrb(data_wstrb), .data_wdata(data_wdata),
        .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok), .data_rdata(data_rdata),
        .mem_req(mem_req), .mem_wr(mem_wr), .mem_size(mem_size), .mem_addr(mem_addr),
        .mem_wstrb(mem_wstrb), .mem_wdata(mem_wdata),
        .mem_addr_ok(mem_addr_ok), .mem_data_ok(mem_data_ok), .mem_rdata(mem_rdata),
        .pending_cnt(pending_cnt), .proto_err(proto_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Drives every input just after a falling edge, then lets the combinational paths settle.
    task automatic applyStimulus(input bit iReq, input bit iWr, input logic [31:0] iAddr,
                                 input bit dReq, input bit dWr, input logic [31:0] dAddr,
                                 input bit mAok, input bit mDok, input logic [31:0] mRdata);
        inst_req    = iReq;
        inst_wr     = iWr;
        inst_addr   = iAddr;
        inst_size   = 2'($urandom_range(0, 2));
        inst_wstrb  = 4'($urandom);
        inst_wdata  = $urandom;
        data_req    = dReq;
        data_wr     = dWr;
        data_addr   = dAddr;
        data_size   = 2'($urandom_range(0, 2));
        data_wstrb  = 4'($urandom);
        data_wdata  = $urandom;
        mem_addr_ok = mAok;
        mem_data_ok = mDok;
        mem_rdata   = mRdata;
        #1;
    endtask

    // Compares every output against the grant/route rules applied to the model queue.
    task automatic checkModel();
        bit full, empty, gd, gi, ret;
        logic [31:0] eAddr, eWdata;
        logic [3:0]  eWstrb;
        logic [1:0]  eSize;
        logic        eWr;
        full  = (q.size() == OUT);
        empty = (q.size() == 0);
        gd    = data_req && !full;
        gi    = inst_req && !data_req && !full;
        eAddr = 0; eWdata = 0; eWstrb = 0; eSize = 0; eWr = 0;
        if (gd) begin
            eAddr = data_addr; eWdata = data_wdata; eWstrb = data_wstrb; eSize = data_size; eWr = data_wr;
        end else if (gi) begin
            eAddr = inst_addr; eWdata = inst_wdata; eWstrb = inst_wstrb; eSize = inst_size; eWr = inst_wr;
        end
        ret = mem_data_ok && !empty;
        checkOutput("mem_req", mem_req, gd || gi);
        checkOutput("mem_addr", mem_addr, eAddr);
        checkOutput("mem_wdata", mem_wdata, eWdata);
        checkOutput("mem_fields", {mem_wr, mem_size, mem_wstrb}, {eWr, eSize, eWstrb});
        checkOutput("data_addr_ok", data_addr_ok, gd && mem_addr_ok);
        checkOutput("inst_addr_ok", inst_addr_ok, gi && mem_addr_ok);
        checkOutput("inst_data_ok", inst_data_ok, ret && q[0] == OWNER_INST);
        checkOutput("data_data_ok", data_data_ok, ret && q[0] == OWNER_DATA);
        checkOutput("rdata", {inst_rdata, data_rdata}, {mem_rdata, mem_rdata});
        checkOutput("pending_cnt", pending_cnt, q.size());
        checkOutput("proto_err", proto_err, mProto);
        lastAcc   = (gd || gi) && mem_addr_ok;
        lastOwner = gd ? OWNER_DATA : OWNER_INST;
        lastRet   = ret;
        lastErr   = mem_data_ok && empty;
    endtask

    task automatic advance();
        @(negedge clk);
        if (lastRet) void'(q.pop_front());
        if (lastAcc) q.push_back(lastOwner);
        if (lastErr) mProto = 1'b1;
    endtask

    task automatic step(input bit iReq, input bit dReq, input bit mAok, input bit mDok,
                        input logic [31:0] mRdata);
        applyStimulus(iReq, 1'b0, 32'h1c000000 + ($urandom & 32'hff0), dReq, 1'b1,
                      32'h1c000100 + ($urandom & 32'hff0), mAok, mDok, mRdata);
        checkModel();
        advance();
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        mProto      = 1'b0;
        resetn      = 1'b0;

        applyStimulus(1, 0, 32'h1c000000, 1, 0, 32'h1c000100, 1, 1, 32'h5a5a5a5a);
        checkOutput("rst_mem_req", mem_req, 0);
        checkOutput("rst_addr_ok", {inst_addr_ok, data_addr_ok}, 0);
        checkOutput("rst_data_ok", {inst_data_ok, data_data_ok}, 0);
        checkOutput("rst_pending", pending_cnt, 0);
        checkOutput("rst_proto", proto_err, 0);
        @(negedge clk);
        @(negedge clk);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
        resetn = 1'b1;
        @(negedge clk);

        $display("[TB] contention");
        applyStimulus(1, 0, 32'h1c000000, 1, 0, 32'h1c000100, 1, 0, 0);
        checkOutput("cont_addr_d", mem_addr, 32'h1c000100);
        checkOutput("cont_dok", data_addr_ok, 1);
        checkOutput("cont_iok0", inst_addr_ok, 0);
        checkModel();
        advance();
        applyStimulus(1, 0, 32'h1c000000, 0, 0, 32'h1c000100, 1, 0, 0);
        checkOutput("cont_addr_i", mem_addr, 32'h1c000000);
        checkOutput("cont_iok1", inst_addr_ok, 1);
        checkModel();
        advance();
        step(0, 0, 0, 1, 32'h1);
        step(0, 0, 0, 1, 32'h2);

        $display("[TB] ordering");
        step(1, 0, 1, 0, 0);
        step(0, 1, 1, 0, 0);
        step(1, 0, 1, 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 32'h11);
        checkOutput("ord1", {inst_data_ok, data_data_ok, inst_rdata}, {1'b1, 1'b0, 32'h11});
        checkModel();
        advance();
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 32'h22);
        checkOutput("ord2", {inst_data_ok, data_data_ok, data_rdata}, {1'b0, 1'b1, 32'h22});
        checkModel();
        advance();
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 32'h33);
        checkOutput("ord3", {inst_data_ok, data_data_ok, inst_rdata}, {1'b1, 1'b0, 32'h33});
        checkModel();
        advance();

        $display("[TB] full");
        for (int i = 0; i < OUT; i++) step(1, i[0], 1, 0, 0);
        applyStimulus(1, 0, 32'h1c000040, 0, 0, 0, 1, 0, 0);
        checkOutput("full_cnt", pending_cnt, 4);
        checkOutput("full_noreq", mem_req, 0);
        checkModel();
        advance();
        applyStimulus(1, 0, 32'h1c000040, 0, 0, 0, 1, 1, 32'h44);
        checkOutput("full_pop_noreq", {mem_req, inst_addr_ok}, 0);
        checkModel();
        advance();
        applyStimulus(1, 0, 32'h1c000040, 0, 0, 0, 1, 0, 0);
        checkOutput("full_cnt3", pending_cnt, 3);
        checkOutput("full_reissue", mem_req, 1);
        checkModel();
        advance();
        checkOutput("full_cnt4", pending_cnt, 4);
        for (int i = 0; i < OUT; i++) step(0, 0, 0, 1, $urandom);

        $display("[TB] simultaneous");
        step(1, 0, 1, 0, 0);
        step(0, 1, 1, 0, 0);
        applyStimulus(0, 0, 0, 1, 0, 32'h1c000200, 1, 1, 32'h66);
        checkOutput("sim_cnt", pending_cnt, 2);
        checkOutput("sim_route", {inst_data_ok, data_data_ok}, 2'b10);
        checkModel();
        advance();
        checkOutput("sim_cnt_after", pending_cnt, 2);
        step(0, 0, 0, 1, 32'h77);
        step(0, 0, 0, 1, 32'h88);

        $display("[TB] error");
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 32'h99);
        checkOutput("err_no_dok", {inst_data_ok, data_data_ok}, 0);
        checkOutput("err_not_yet", proto_err, 0);
        checkModel();
        advance();
        checkOutput("err_set", proto_err, 1);
        step(0, 0, 0, 0, 0);
        checkOutput("err_sticky", proto_err, 1);

        $display("[TB] random");
        for (int i = 0; i < 400; i++) begin
            bit dok;
            dok = (q.size() > 0) && ($urandom_range(0, 2) == 0);
            applyStimulus($urandom_range(0, 3) != 0, $urandom, 32'h1c000000 | ($urandom & 32'hfffc),
                          $urandom_range(0, 2) == 0, $urandom, 32'h1c100000 | ($urandom & 32'hfffc),
                          $urandom_range(0, 1) == 1, dok, $urandom);
            checkModel();
            advance();
        end

        $display("[TB] async reset");
        step(1, 0, 1, 0, 0);
        applyStimulus(1, 1, 32'h1c000300, 1, 1, 32'h1c000400, 1, 1, 0);
        #1 resetn = 1'b0;
        #1;
        checkOutput("arst_pending", pending_cnt, 0);
        checkOutput("arst_proto", proto_err, 0);
        checkOutput("arst_outs", {mem_req, inst_addr_ok, data_addr_ok, inst_data_ok, data_data_ok}, 0);
        q.delete();
        mProto = 1'b0;
        @(negedge clk);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
        resetn = 1'b1;
        @(negedge clk);
        step(0, 1, 1, 0, 0);
        step(0, 0, 0, 1, 32'habc);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
